// File: rtl/nasti_lite_uart_console.sv
// NASTI-Lite master for a UART slave: core TX bytes become single-beat writes, continuous polled reads fill an RX stream.
// Build option: define UART_CONSOLE_ERR_EN to add a sticky err output flagging non-OKAY write responses.
//
// state  | meaning
// W_IDLE | no write in flight, waiting for a TX byte
// W_ADDR | AW and/or W still waiting for their handshakes
// W_RESP | both sent, waiting for B
// R_IDLE | no read in flight, waiting for RX FIFO space
// R_ADDR | AR presented, waiting for the UART to accept it
// R_DATA | waiting for the read data beat
module nasti_lite_uart_console #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] UART_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
`ifdef UART_CONSOLE_ERR_EN
  output logic                  err,
`endif
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_strb,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [1:0]            b_resp,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_WIDTH-1:0] r_data
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_FULL = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL = (RXA+1)'(RX_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [TXA-1:0]        tx_wr_q, tx_rd_q;
  logic [TXA:0]          tx_cnt_q;
  logic                  tx_push, tx_pop;

  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [RXA-1:0]        rx_wr_q, rx_rd_q;
  logic [RXA:0]          rx_cnt_q;
  logic                  rx_push, rx_pop;

  logic                  aw_valid_d, w_valid_d, load;
  logic [DATA_WIDTH-1:0] w_data_d;

  assign aw_addr = UART_ADDR;
  assign ar_addr = UART_ADDR;
  assign w_strb  = 1'b1;

  // TX FIFO
  assign tx_ready = (tx_cnt_q != TX_FULL);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = load;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
        2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // RX FIFO; the read FSM only issues AR when there is room, so push never overflows
  assign rx_valid = (rx_cnt_q != '0);
  assign rx_data  = rx_mem[rx_rd_q];
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_push  = r_ready & r_valid;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= r_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
        2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Write FSM; a waiting byte is loaded straight from W_RESP so writes run back-to-back
  always_comb begin
    w_state_d  = w_state_q;
    aw_valid_d = aw_valid;
    w_valid_d  = w_valid;
    w_data_d   = w_data;
    b_ready    = 1'b0;
    load       = 1'b0;
    case (w_state_q)
      W_IDLE: load = (tx_cnt_q != '0);
      W_ADDR: begin
        if (aw_ready) aw_valid_d = 1'b0;
        if (w_ready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_ready = 1'b1;
        if (b_valid) begin
          w_state_d = W_IDLE;
          load      = (tx_cnt_q != '0);
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (load) begin
      w_state_d  = W_ADDR;
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      w_data_d   = tx_mem[tx_rd_q];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      w_data    <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_valid  <= aw_valid_d;
      w_valid   <= w_valid_d;
      w_data    <= w_data_d;
    end
  end

  // Read FSM
  always_comb begin
    r_state_d = r_state_q;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (r_state_q)
      R_IDLE: if (rx_cnt_q != RX_FULL) r_state_d = R_ADDR;
      R_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_ready = 1'b1;
        if (r_valid) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

`ifdef UART_CONSOLE_ERR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                      err <= 1'b0;
    else if (b_valid && b_ready && b_resp != 2'b00) err <= 1'b1;
  end
`else
  logic unused_b_resp;
  assign unused_b_resp = ^b_resp;
`endif

endmodule

// File: tb/tb_nasti_lite_uart_console.sv
// Self-checking bench for nasti_lite_uart_console: reactive NASTI slave model plus TX/RX scoreboards.
// Define UART_CONSOLE_ERR_EN for both files to exercise the err flag.
module tb_nasti_lite_uart_console;

  logic       clk = 1'b0;
  logic       rstn;
`ifdef UART_CONSOLE_ERR_EN
  logic       err;
`endif
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       aw_valid, aw_ready;
  logic [7:0] aw_addr;
  logic       w_valid, w_ready;
  logic [7:0] w_data;
  logic       w_strb;
  logic       b_valid, b_ready;
  logic [1:0] b_resp;
  logic       ar_valid, ar_ready;
  logic [7:0] ar_addr;
  logic       r_valid, r_ready;
  logic [7:0] r_data;

  nasti_lite_uart_console dut (
    .clk(clk), .rstn(rstn),
`ifdef UART_CONSOLE_ERR_EN
    .err(err),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_w[$];
  logic [7:0] exp_r[$];
  logic [7:0] src_q[$];
  logic [1:0] resp_q[$];

  // slave knobs (written by the main sequence just after posedge)
  int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0;
  logic aw_stall = 1'b0, r_stall = 1'b0;

  // slave progress counters
  int wr_done = 0, aw_issued = 0, w_hs = 0, rd_done = 0, rx_pops = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_accept", tx_ready, 1'b1);
    if (tx_ready) exp_w.push_back(b);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // write-side slave: AW / W / B
  initial begin
    int aw_wait, w_wait, b_wait;
    logic aw_done, w_done, b_fire;
    logic [7:0] e;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    aw_done = 1'b0; w_done = 1'b0; b_fire = 1'b0;
    aw_wait = 0; w_wait = 0; b_wait = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; b_fire = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        aw_issued = wr_done;
      end else begin
        if (b_fire) begin
          b_valid = 1'b0; b_fire = 1'b0;
          aw_done = 1'b0; w_done = 1'b0;
          wr_done++;
        end
        if (aw_ready) begin
          aw_ready = 1'b0; aw_done = 1'b1;
        end else if (aw_valid && !aw_done && !aw_stall) begin
          if (aw_wait >= aw_dly) begin
            aw_ready = 1'b1; aw_wait = 0;
            check_val("aw_addr", aw_addr, 8'h00);
            check_val("one_outstanding", aw_issued - wr_done, 0);
            aw_issued++;
          end else aw_wait++;
        end
        if (aw_done) check_val("aw_no_dup", aw_valid, 1'b0);
        if (w_ready) begin
          w_ready = 1'b0; w_done = 1'b1; w_hs++;
        end else if (w_valid && !w_done) begin
          if (w_wait >= w_dly) begin
            w_ready = 1'b1; w_wait = 0;
            check_val("w_expected", exp_w.size() != 0, 1'b1);
            e = (exp_w.size() != 0) ? exp_w.pop_front() : 8'hxx;
            check_val("w_data", w_data, e);
            check_val("w_strb", w_strb, 1'b1);
          end else w_wait++;
        end
        if (w_done) check_val("w_no_dup", w_valid, 1'b0);
        if (aw_done && w_done && !b_valid) begin
          if (b_wait >= b_dly) begin
            b_valid = 1'b1; b_wait = 0;
            b_resp = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
          end else b_wait++;
        end
        if (b_valid && b_ready) b_fire = 1'b1;
      end
    end
  end

  // read-side slave: AR / R
  initial begin
    int ar_wait;
    logic ar_done, r_fire;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = 8'h00;
    ar_wait = 0; ar_done = 1'b0; r_fire = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ar_ready = 1'b0; r_valid = 1'b0;
        ar_wait = 0; ar_done = 1'b0; r_fire = 1'b0;
      end else begin
        if (r_fire) begin
          r_valid = 1'b0; r_fire = 1'b0; ar_done = 1'b0;
          rd_done++;
        end
        if (ar_ready) begin
          ar_ready = 1'b0; ar_done = 1'b1;
        end else if (ar_valid && !ar_done && src_q.size() != 0) begin
          if (ar_wait >= ar_dly) begin
            ar_ready = 1'b1; ar_wait = 0;
            check_val("ar_addr", ar_addr, 8'h00);
          end else ar_wait++;
        end
        if (ar_done && !r_valid && !r_stall && src_q.size() != 0) begin
          r_data  = src_q.pop_front();
          r_valid = 1'b1;
          exp_r.push_back(r_data);
        end
        if (r_valid && r_ready) r_fire = 1'b1;
      end
    end
  end

  // RX consumer scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rstn && rx_valid && rx_ready) begin
        check_val("rx_expected", exp_r.size() != 0, 1'b1);
        e = (exp_r.size() != 0) ? exp_r.pop_front() : 8'hxx;
        check_val("rx_data", rx_data, e);
        rx_pops++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pbase;
    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    step(3);
    check_val("rst_aw_valid", aw_valid, 1'b0);
    check_val("rst_w_valid", w_valid, 1'b0);
    check_val("rst_b_ready", b_ready, 1'b0);
    check_val("rst_ar_valid", ar_valid, 1'b0);
    check_val("rst_r_ready", r_ready, 1'b0);
    check_val("rst_rx_valid", rx_valid, 1'b0);
    check_val("rst_tx_ready", tx_ready, 1'b1);
`ifdef UART_CONSOLE_ERR_EN
    check_val("rst_err", err, 1'b0);
`endif
    rstn = 1'b1;
    step(2);

    // 1: three bytes, fast slave, in order, 1-cycle head-to-aw_valid latency
    base = wr_done;
    push_byte(8'h41);
    check_val("t1_aw_lat_before", aw_valid, 1'b0);
    step(1);
    check_val("t1_aw_lat_after", aw_valid, 1'b1);
    check_val("t1_w_valid", w_valid, 1'b1);
    push_byte(8'h42);
    push_byte(8'h43);
    for (int i = 0; i < 200 && wr_done < base + 3; i++) step(1);
    check_val("t1_writes", wr_done, base + 3);

    // 2: W accepted well before AW
    base = wr_done;
    aw_dly = 4; w_dly = 0;
    push_byte(8'h55);
    for (int i = 0; i < 50 && w_hs == 0 + w_hs && wr_done == base && !(w_valid == 1'b0 && aw_valid == 1'b1); i++) step(1);
    @(negedge clk);
    check_val("t2_w_dropped", w_valid, 1'b0);
    check_val("t2_aw_held", aw_valid, 1'b1);
    check_val("t2_no_bready", b_ready, 1'b0);
    step(1);
    for (int i = 0; i < 50 && wr_done < base + 1; i++) step(1);
    check_val("t2_writes", wr_done, base + 1);
    aw_dly = 0;

    // 3: 17 bytes against a stalled AW, then drain
    base = wr_done;
    aw_stall = 1'b1;
    for (int i = 0; i < 17; i++) push_byte(8'h60 + 8'(i));
    @(negedge clk);
    check_val("t3_tx_full", tx_ready, 1'b0);
    check_val("t3_aw_held", aw_valid, 1'b1);
    step(1);
    aw_stall = 1'b0;
    for (int i = 0; i < 400 && wr_done < base + 17; i++) step(1);
    check_val("t3_writes", wr_done, base + 17);
    check_val("t3_tx_ready", tx_ready, 1'b1);

    // 4: RX fills with core stalled, AR stops; one pop re-issues AR next cycle
    base = rd_done; pbase = rx_pops;
    for (int i = 0; i < 18; i++) src_q.push_back(8'(i));
    for (int i = 0; i < 300 && rd_done < base + 16; i++) step(1);
    step(10);
    check_val("t4_reads_at_full", rd_done, base + 16);
    check_val("t4_ar_idle", ar_valid, 1'b0);
    check_val("t4_rx_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    check_val("t4_ar_not_yet", ar_valid, 1'b0);
    step(1);
    check_val("t4_ar_reissue", ar_valid, 1'b1);
    for (int i = 0; i < 50 && rd_done < base + 17; i++) step(1);
    check_val("t4_reads_refill", rd_done, base + 17);
    rx_ready = 1'b1;
    for (int i = 0; i < 300 && rx_pops < pbase + 18; i++) step(1);
    check_val("t4_pops", rx_pops, pbase + 18);

    // 5: reset mid-flight (W_ADDR and R_DATA)
    aw_stall = 1'b1; r_stall = 1'b1;
    src_q.push_back(8'hA5);
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < 50 && !(r_ready && aw_valid); i++) step(1);
    check_val("t5_in_r_data", r_ready, 1'b1);
    check_val("t5_in_w_addr", aw_valid, 1'b1);
    rstn = 1'b0;
    #1;
    check_val("t5_aw_valid", aw_valid, 1'b0);
    check_val("t5_w_valid", w_valid, 1'b0);
    check_val("t5_b_ready", b_ready, 1'b0);
    check_val("t5_ar_valid", ar_valid, 1'b0);
    check_val("t5_r_ready", r_ready, 1'b0);
    check_val("t5_rx_valid", rx_valid, 1'b0);
    check_val("t5_tx_ready", tx_ready, 1'b1);
    exp_w.delete(); exp_r.delete(); src_q.delete(); resp_q.delete();
    step(2);
    rstn = 1'b1;
    aw_stall = 1'b0; r_stall = 1'b0;
    step(1);
    base = wr_done; pbase = rx_pops;
    src_q.push_back(8'h5A);
    push_byte(8'h77);
    for (int i = 0; i < 100 && (wr_done < base + 1 || rx_pops < pbase + 1); i++) step(1);
    check_val("t5_write_resumes", wr_done, base + 1);
    check_val("t5_read_resumes", rx_pops, pbase + 1);

`ifdef UART_CONSOLE_ERR_EN
    // 6: error response on the second write
    base = wr_done;
    check_val("t6_err_clear", err, 1'b0);
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    for (int i = 0; i < 100 && wr_done < base + 1; i++) step(1);
    check_val("t6_err_after_ok", err, 1'b0);
    for (int i = 0; i < 100 && wr_done < base + 2; i++) step(1);
    check_val("t6_err_set", err, 1'b1);
    for (int i = 0; i < 100 && wr_done < base + 3; i++) step(1);
    check_val("t6_third_write", wr_done, base + 3);
    check_val("t6_err_sticky", err, 1'b1);
`endif

    step(5);
    check_val("end_w_queue", exp_w.size(), 0);
    check_val("end_r_queue", exp_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
